serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits; legal range 2..16.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: START  input  1  request to begin a subtraction; sampled on rising CLK.
REQ-005 Port: NUM1  input  WIDTH  minuend, unsigned; sampled only on the accepting edge.
REQ-006 Port: NUM2  input  WIDTH  subtrahend, unsigned; sampled only on the accepting edge.
REQ-007 Port: BIN  input  1  borrow-in; sampled only on the accepting edge.
REQ-008 Port: BUSY  output  1  high while an operation is in progress (state SHIFT).
REQ-009 Port: DONE  output  1  one-cycle completion pulse (state DONE).
REQ-010 Port: DIFF  output  WIDTH  registered result, NUM1 - NUM2 - BIN modulo 2^WIDTH.
REQ-011 Port: BOUT  output  1  registered borrow-out; 1 iff NUM1 < NUM2 + BIN (unsigned).

Function
REQ-012 FSM: three states, IDLE, SHIFT, DONE; only IDLE accepts START.
REQ-013 IDLE: START=1 at an edge -> latch NUM1, NUM2 into internal shift registers, load borrow flop with BIN, clear bit counter, go to SHIFT; START=0 -> stay IDLE.
REQ-014 SHIFT: one bit per edge, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br); d shifted into result register from the MSB end; operand registers shift right; counter increments.
REQ-015 SHIFT -> DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1); that same edge loads DIFF with the completed result and BOUT with br_next.
REQ-016 DONE -> IDLE on the next edge, unconditionally; START in DONE is ignored.
REQ-017 Latency: START accepted at edge k -> DONE high from edge k+WIDTH to edge k+WIDTH+1; minimum START-to-START spacing WIDTH+2 cycles.
REQ-018 BUSY = 1 exactly in SHIFT; DONE = 1 exactly in DONE; never both high.
REQ-019 START, NUM1, NUM2, BIN changes during SHIFT/DONE have no effect on the operation in flight.
REQ-020 DIFF/BOUT change only on the completion edge (REQ-015) or reset; they hold the last result through IDLE and the next SHIFT.
REQ-021 Wrap-around: results below zero wrap modulo 2^WIDTH with BOUT=1; no saturation.
REQ-022 Counter width ceil(log2(WIDTH)); no count beyond WIDTH-1.

Reset
REQ-023 RST_N low -> immediately, without a clock: state IDLE, BUSY=0, DONE=0, DIFF=0, BOUT=0, counter/shift/borrow registers 0.
REQ-024 Reset asserted mid-SHIFT or in DONE aborts the operation; no DONE pulse and no DIFF/BOUT update for the aborted operation.
REQ-025 First START accepted on the first rising edge at which RST_N is high.

Verification (WIDTH=4)
REQ-026 NUM1=9, NUM2=6, BIN=0, START pulse -> BUSY 4 cycles, DONE 1 cycle, DIFF=4'b0011, BOUT=0.
REQ-027 NUM1=6, NUM2=9, BIN=0 -> DIFF=4'b1101, BOUT=1; NUM1=9, NUM2=6, BIN=1 -> DIFF=4'b0010, BOUT=0.
REQ-028 NUM1=0, NUM2=0, BIN=1 -> DIFF=4'b1111, BOUT=1; NUM1=15, NUM2=15, BIN=0 -> DIFF=0, BOUT=0.
REQ-029 START held high continuously with operands changed every cycle -> operations start every 6 cycles, each result matches operands latched at its accepting edge.
REQ-030 RST_N pulsed low 2 cycles into SHIFT -> outputs 0 asynchronously, no DONE; next START (9,6,0) completes correctly with DIFF=3.
REQ-031 Exhaustive: all 512 NUM1/NUM2/BIN combinations -> {BOUT,DIFF} equals 5-bit (NUM1 - NUM2 - BIN) mod 32 for every operation.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes NUM1 - NUM2 - BIN one bit per clock,
// LSB first, and reports the result with a borrow-out and a one-cycle DONE pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] NUM1,
  input  logic [WIDTH-1:0] NUM2,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Full-subtractor cell on the current LSBs
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DIFF    <= '0;
      BOUT    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      BUSY    <= (w_state_nxt == ST_SHIFT);
      DONE    <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_a   <= NUM1;
            r_b   <= NUM2;
            r_br  <= BIN;
            r_res <= '0;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_res <= w_res_nxt;
          // Counter parks at zero after the final bit rather than wrapping past WIDTH-1
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (w_last) begin
            DIFF <= w_res_nxt;
            BOUT <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
